// File: rtl/maze_pkg.sv
// Shared types and constants for the 16x16 maze depth-first-search solver.
//   - FSM state encoding
//   - direction codes (E, S, W, N) and their per-axis coordinate steps
//   - wall polarity of a maze cell
//   - path stack entry layout {x, y, dir}
package maze_pkg;

    localparam int COORD_W = 4;
    localparam logic WALL = 1'b1;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [2:0]         dir_t;

    // Directions are tried in this numeric order; DIR_END means all four exhausted.
    localparam dir_t DIR_E   = 3'd0;
    localparam dir_t DIR_S   = 3'd1;
    localparam dir_t DIR_W   = 3'd2;
    localparam dir_t DIR_N   = 3'd3;
    localparam dir_t DIR_END = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MARK,
        PROBE,
        BACK,
        EMIT,
        DONE,
        FAIL
    } state_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        dir_t   dir;
    } stack_entry_t;

    // Coordinate steps as modulo-16 addends: a wrap only occurs for an
    // out-of-bounds neighbour, which is never read.
    function automatic coord_t dir_dx(input dir_t d);
        case (d)
            DIR_E:   dir_dx = coord_t'(1);
            DIR_W:   dir_dx = '1;
            default: dir_dx = '0;
        endcase
    endfunction

    function automatic coord_t dir_dy(input dir_t d);
        case (d)
            DIR_S:   dir_dy = coord_t'(1);
            DIR_N:   dir_dy = '1;
            default: dir_dy = '0;
        endcase
    endfunction

endpackage

// File: rtl/maze_path_stack.sv
// LIFO holding the current search path, one entry per cell on the path.
//   clk, rst_n   : clock, asynchronous active-low reset (clears sp only)
//   clear        : empty the stack
//   push         : write push_entry at sp, sp+1
//   pop          : sp-1
//   upd_dir      : overwrite dir field of the top entry with new_dir
//   rd_idx       : combinational indexed read (rd_entry), used for backtrack and path emission
//   sp           : number of valid entries
module maze_path_stack
    import maze_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int SP_W  = $clog2(DEPTH + 1),
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  stack_entry_t     push_entry,
    input  logic             pop,
    input  logic             upd_dir,
    input  dir_t             new_dir,
    input  logic [IDX_W-1:0] rd_idx,
    output stack_entry_t     rd_entry,
    output logic [SP_W-1:0]  sp
);

    logic [SP_W-1:0]  sp_q, sp_d;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;
    stack_entry_t     entries_q [DEPTH];

    // Each cell is pushed at most once per search, so sp never exceeds DEPTH
    // and wr_idx never wraps while a push is issued.
    assign wr_idx  = sp_q[IDX_W-1:0];
    assign top_idx = IDX_W'(sp_q - SP_W'(1));

    always_comb begin
        sp_d = sp_q;
        if (clear) begin
            sp_d = '0;
        end else if (push) begin
            sp_d = sp_q + SP_W'(1);
        end else if (pop) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Storage carries no reset; only entries below sp are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            entries_q[wr_idx] <= push_entry;
        end else if (upd_dir) begin
            entries_q[top_idx].dir <= new_dir;
        end
    end

    assign rd_entry = entries_q[rd_idx];
    assign sp       = sp_q;

endmodule

// File: rtl/maze_dfs_solver.sv
// Depth-first maze solver driving a single-port 16x16 bit-map maze memory.
// Open cells read 0, walls read 1; visited cells are overwritten with 1.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : request a solve (ignored while busy)
//   busy / done / fail  : search status
//   mem_x/y/rd/wr/din   : memory request; mem_dout is the same-cycle read data
//   path_valid/x/y/last : start-to-goal path stream, one cell per cycle
//   path_len            : number of path cells, valid during emission and done
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start after reset
// CHECK | read start cell; wall -> FAIL
// MARK  | write 1 to cur, push {cur, E}; goal -> EMIT
// PROBE | test neighbour in top-of-stack direction, one direction per cycle
// BACK  | pop; empty -> FAIL, else resume the new top at its next direction
// EMIT  | stream stack entries 0..sp-1
// DONE  | path found, done held
// FAIL  | no path, fail held
module maze_dfs_solver
    import maze_pkg::*;
#(
    parameter int W       = 16,
    parameter int H       = 16,
    parameter int START_X = 0,
    parameter int START_Y = 0,
    parameter int GOAL_X  = 15,
    parameter int GOAL_Y  = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [COORD_W-1:0] mem_x,
    output logic [COORD_W-1:0] mem_y,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               mem_din,
    input  logic               mem_dout,
    output logic               path_valid,
    output logic [COORD_W-1:0] path_x,
    output logic [COORD_W-1:0] path_y,
    output logic               path_last,
    output logic [8:0]         path_len
);

    localparam int DEPTH = W * H;
    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    localparam coord_t X_MAX = coord_t'(W - 1);
    localparam coord_t Y_MAX = coord_t'(H - 1);
    localparam coord_t SX    = coord_t'(START_X);
    localparam coord_t SY    = coord_t'(START_Y);
    localparam coord_t GX    = coord_t'(GOAL_X);
    localparam coord_t GY    = coord_t'(GOAL_Y);

    state_t           state_q, state_d;
    coord_t           cur_x_q, cur_x_d;
    coord_t           cur_y_q, cur_y_d;
    dir_t             dir_q, dir_d;
    logic [IDX_W-1:0] emit_idx_q, emit_idx_d;

    logic             stk_clear;
    logic             stk_push;
    logic             stk_pop;
    logic             stk_upd;
    stack_entry_t     push_entry;
    logic [IDX_W-1:0] rd_idx;
    stack_entry_t     rd_entry;
    logic [SP_W-1:0]  sp;

    coord_t           nb_x;
    coord_t           nb_y;
    logic             nb_oob;
    logic             emit_last;

    assign push_entry = '{x: cur_x_q, y: cur_y_q, dir: DIR_E};

    maze_path_stack #(
        .DEPTH (DEPTH),
        .SP_W  (SP_W),
        .IDX_W (IDX_W)
    ) u_stack (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (stk_clear),
        .push       (stk_push),
        .push_entry (push_entry),
        .pop        (stk_pop),
        .upd_dir    (stk_upd),
        .new_dir    (dir_q),
        .rd_idx     (rd_idx),
        .rd_entry   (rd_entry),
        .sp         (sp)
    );

    // In BACK the read port looks one below the top: that entry becomes the new top.
    always_comb begin
        rd_idx = emit_idx_q;
        if (state_q == BACK) begin
            rd_idx = IDX_W'(sp - SP_W'(2));
        end
    end

    always_comb begin
        nb_x = cur_x_q + dir_dx(dir_q);
        nb_y = cur_y_q + dir_dy(dir_q);
        case (dir_q)
            DIR_E:   nb_oob = (cur_x_q == X_MAX);
            DIR_S:   nb_oob = (cur_y_q == Y_MAX);
            DIR_W:   nb_oob = (cur_x_q == '0);
            DIR_N:   nb_oob = (cur_y_q == '0);
            default: nb_oob = 1'b1;
        endcase
    end

    assign emit_last = (emit_idx_q == IDX_W'(sp - SP_W'(1)));

    always_comb begin
        state_d    = state_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        dir_d      = dir_q;
        emit_idx_d = emit_idx_q;
        stk_clear  = 1'b0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        stk_upd    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        fail       = 1'b0;
        mem_x      = '0;
        mem_y      = '0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_din    = 1'b0;
        path_valid = 1'b0;
        path_x     = '0;
        path_y     = '0;
        path_last  = 1'b0;
        path_len   = '0;

        case (state_q)
            IDLE, DONE, FAIL: begin
                done = (state_q == DONE);
                fail = (state_q == FAIL);
                if (state_q == DONE) begin
                    path_len = 9'(sp);
                end
                if (start) begin
                    state_d   = CHECK;
                    cur_x_d   = SX;
                    cur_y_d   = SY;
                    stk_clear = 1'b1;
                end
            end

            CHECK: begin
                busy   = 1'b1;
                mem_rd = 1'b1;
                mem_x  = cur_x_q;
                mem_y  = cur_y_q;
                state_d = (mem_dout == WALL) ? FAIL : MARK;
            end

            MARK: begin
                busy     = 1'b1;
                mem_wr   = 1'b1;
                mem_din  = 1'b1;
                mem_x    = cur_x_q;
                mem_y    = cur_y_q;
                stk_push = 1'b1;
                dir_d    = DIR_E;
                if (cur_x_q == GX && cur_y_q == GY) begin
                    state_d    = EMIT;
                    emit_idx_d = '0;
                end else begin
                    state_d = PROBE;
                end
            end

            PROBE: begin
                busy = 1'b1;
                if (dir_q >= DIR_END) begin
                    // Resumed past the last direction after a backtrack.
                    state_d = BACK;
                end else begin
                    if (!nb_oob) begin
                        mem_rd = 1'b1;
                        mem_x  = nb_x;
                        mem_y  = nb_y;
                    end
                    if (!nb_oob && mem_dout != WALL) begin
                        stk_upd = 1'b1;
                        cur_x_d = nb_x;
                        cur_y_d = nb_y;
                        state_d = MARK;
                    end else if (dir_q == DIR_N) begin
                        state_d = BACK;
                    end else begin
                        dir_d = dir_q + dir_t'(1);
                    end
                end
            end

            BACK: begin
                busy    = 1'b1;
                stk_pop = 1'b1;
                if (sp == SP_W'(1)) begin
                    state_d = FAIL;
                end else begin
                    cur_x_d = rd_entry.x;
                    cur_y_d = rd_entry.y;
                    dir_d   = rd_entry.dir + dir_t'(1);
                    state_d = PROBE;
                end
            end

            EMIT: begin
                busy       = 1'b1;
                path_valid = 1'b1;
                path_x     = rd_entry.x;
                path_y     = rd_entry.y;
                path_last  = emit_last;
                path_len   = 9'(sp);
                if (emit_last) begin
                    state_d = DONE;
                end else begin
                    emit_idx_d = emit_idx_q + IDX_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            dir_q      <= DIR_E;
            emit_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            dir_q      <= dir_d;
            emit_idx_q <= emit_idx_d;
        end
    end

endmodule
